// File: rtl/gray_count_stream.sv
// Gray-code count sequencer with a valid/ready output stream, load port and one-entry pending load.
// Optional wrap sideband is built when GRAY_CNT_WRAP_FLAG_EN is defined.
module gray_count_stream #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out
`ifdef GRAY_CNT_WRAP_FLAG_EN
    ,
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`ifdef GRAY_CNT_WRAP_FLAG_EN
    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic             fresh_q, fresh_d;
    logic             pend_vld_q, pend_vld_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
`ifdef GRAY_CNT_WRAP_FLAG_EN
    logic             wrap_q, wrap_d;
`endif

    logic             slot_free;
    logic             beat;
    logic             apply_load;
    logic             fresh_eff;
    logic [WIDTH-1:0] step_val;

    // The output register may be rewritten when empty or when its beat is being accepted.
    assign slot_free = (state_q == IDLE) || out_ready;
    assign beat      = slot_free && en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (slot_free) begin
            state_d = en ? ACTIVE : IDLE;
        end
    end

    always_comb begin
        out_valid = (state_q == ACTIVE);
    end

    // A fresh load (direct, or the pending one) wins over stepping and rebases the count.
    always_comb begin
        apply_load = slot_free && (load || pend_vld_q);
        base_d     = base_q;
        if (apply_load) begin
            base_d = load ? load_val : pend_val_q;
        end
        fresh_eff = apply_load || fresh_q;
        fresh_d   = beat ? 1'b0 : fresh_eff;

        pend_vld_d = pend_vld_q;
        pend_val_d = pend_val_q;
        if (slot_free) begin
            pend_vld_d = 1'b0;
        end else if (load) begin
            pend_vld_d = 1'b1;
            pend_val_d = load_val;
        end

        step_val = up_dn ? (bin_q + ONE) : (bin_q - ONE);
        bin_d    = bin_q;
        if (beat) begin
            bin_d = fresh_eff ? base_d : step_val;
        end
        gray_d = bin_d ^ (bin_d >> 1);

`ifdef GRAY_CNT_WRAP_FLAG_EN
        wrap_d = wrap_q;
        if (beat) begin
            wrap_d = !fresh_eff && (up_dn ? (bin_q == MAX_VAL) : (bin_q == '0));
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            gray_q     <= '0;
            base_q     <= '0;
            fresh_q    <= 1'b1;
            pend_vld_q <= 1'b0;
            pend_val_q <= '0;
        end else begin
            bin_q      <= bin_d;
            gray_q     <= gray_d;
            base_q     <= base_d;
            fresh_q    <= fresh_d;
            pend_vld_q <= pend_vld_d;
            pend_val_q <= pend_val_d;
        end
    end

`ifdef GRAY_CNT_WRAP_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

    assign bin_out  = bin_q;
    assign gray_out = gray_q;

endmodule

// File: doc/gray_count_stream.md
GRAY_COUNT_STREAM -- requirements
Module: gray_count_stream

Interface
REQ-001 Parameter WIDTH, default 4, counter and code width in bits (legal range 2..16).
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port en  input  1  count enable; sequencer produces beats only while high.
REQ-005 Port up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled when a stepped value is generated.
REQ-006 Port load  input  1  single-cycle load request.
REQ-007 Port load_val  input  WIDTH  binary value to load.
REQ-008 Port out_valid  output  1  output beat valid.
REQ-009 Port out_ready  input  1  downstream accepts beat when high with out_valid.
REQ-010 Port bin_out  output  WIDTH  registered binary count of current beat.
REQ-011 Port gray_out  output  WIDTH  registered Gray code of bin_out.
REQ-012 Port wrap  output  1  beat sideband: value produced by modular wrap (present only under GRAY_CNT_WRAP_FLAG_EN).

Function
REQ-013 Block SHALL hold one output register (bin_out, gray_out, wrap) and a state machine with states IDLE (out_valid=0) and ACTIVE (out_valid=1).
REQ-014 "Slot free" SHALL mean state IDLE, or ACTIVE with out_ready=1 (handshake) in the current cycle.
REQ-015 gray_out SHALL equal bin_out XOR (bin_out >> 1), loaded into its register in the same cycle as bin_out; zero added latency between them.
REQ-016 A fresh flag SHALL be set by reset and by any applied load; the next beat after fresh presents the base value unstepped, then clears fresh.
REQ-017 A non-fresh beat SHALL present previous bin_out +1 (up_dn=1) or -1 (up_dn=0), modulo 2^WIDTH.
REQ-018 IDLE and en=1: next cycle SHALL enter ACTIVE presenting the next value per REQ-016/017.
REQ-019 ACTIVE and out_ready=0: bin_out, gray_out, wrap, out_valid SHALL hold stable.
REQ-020 ACTIVE, handshake, en=1: next cycle SHALL present the next value, staying ACTIVE (one beat per cycle sustained).
REQ-021 ACTIVE, handshake, en=0: next cycle SHALL return to IDLE; bin_out retains last value.
REQ-022 load while slot free SHALL be applied immediately: base value = load_val, fresh set; if en=1 the loaded value is the next beat.
REQ-023 load while slot not free SHALL be latched into a one-entry pending register and applied at the next slot-free cycle; a newer load overwrites the pending one.
REQ-024 load and en simultaneous in slot-free cycle: load SHALL take priority; presented beat = load_val.
REQ-025 wrap SHALL be 1 only on a stepped beat going max->0 (up) or 0->max (down); 0 on fresh beats.
REQ-026 Combinational path from out_ready to out_valid or data outputs SHALL NOT exist.

Reset
REQ-027 rst asserted SHALL immediately force: state IDLE, out_valid=0, bin_out=0, gray_out=0, wrap=0, pending cleared, fresh=1.
REQ-028 rst asserted mid-beat SHALL drop the beat without handshake; first beat after release with en=1 is 0.
REQ-029 Release of rst SHALL be treated synchronously by the integration; no beat in the release cycle.

Configuration
REQ-030 Macro GRAY_CNT_WRAP_FLAG_EN defined: wrap port and its register exist per REQ-025.
REQ-031 Macro undefined: wrap port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=4)
REQ-032 Reset, en=1, up_dn=1, out_ready=1 -> beats bin 0,1,2,3 gray 0000,0001,0011,0010 ... bin 15 gray 1000, then bin 0 gray 0000 wrap=1.
REQ-033 Beat bin 5 (gray 0111) with out_ready=0 for 3 cycles -> outputs stable 3 cycles; out_ready=1 -> next beat bin 6 gray 0101.
REQ-034 load_val=4'hA pulsed during stall on bin 3 -> after handshake next beat bin A gray 1111 wrap=0, then bin B gray 1110.
REQ-035 load_val=0, up_dn=0, en=1 -> beats 0, 15 (gray 1000, wrap=1), 14 (gray 1001).
REQ-036 rst pulsed while ACTIVE on bin 9 -> out_valid=0 and bin_out=0 same cycle without clock edge; after release first beat bin 0.
REQ-037 en=0 at handshake of bin 7 -> IDLE, out_valid=0; en=1 later -> beat bin 8 gray 1100.
